// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32I execute stage: opcodes, ALU operation codes
// and branch funct3 values.
package rv32_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_SLL  = 4'b0010,
      ALU_SLT  = 4'b0011,
      ALU_SLTU = 4'b0100,
      ALU_XOR  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_OR   = 4'b1000,
      ALU_AND  = 4'b1001
   } alu_op_t;

   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_BLT  = 3'b100;
   localparam logic [2:0] BR_BGE  = 3'b101;
   localparam logic [2:0] BR_BLTU = 3'b110;
   localparam logic [2:0] BR_BGEU = 3'b111;

endpackage

// File: rtl/rv32_alu_core.sv
// Pure combinational 32-bit integer ALU with zero and signed/unsigned compare flags.
module rv32_alu_core
   import rv32_pkg::*;
(
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  alu_op_t         alu_op,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            less_than,
   output logic            less_than_u
);

   logic [4:0] shamt_s;

   assign shamt_s     = b[4:0];
   assign less_than   = ($signed(a) < $signed(b));
   assign less_than_u = (a < b);
   assign zero        = (result == 32'd0);

   // Operation select
   always_comb begin
      result = 32'd0;
      case (alu_op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_SLL:  result = a << shamt_s;
         ALU_SLT:  result = {31'd0, less_than};
         ALU_SLTU: result = {31'd0, less_than_u};
         ALU_XOR:  result = a ^ b;
         ALU_SRL:  result = a >> shamt_s;
         ALU_SRA:  result = $unsigned($signed(a) >>> shamt_s);
         ALU_OR:   result = a | b;
         ALU_AND:  result = a & b;
         default:  result = 32'd0;
      endcase
   end

endmodule

// File: rtl/rv32_exec_unit.sv
// Execute stage of the multicycle RV32I core: ALU-op decode, ALU, branch
// condition and the result register consumed by the following cycle.
module rv32_exec_unit
   import rv32_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic             is_branch,
   input  logic             is_jalr,
   input  logic [XLEN-1:0]  a,
   input  logic [XLEN-1:0]  b,
   output logic [3:0]       alu_op,
   output logic [XLEN-1:0]  result,
   output logic [XLEN-1:0]  result_q,
   output logic             zero,
   output logic             less_than,
   output logic             less_than_u,
   output logic             take_branch
);

   alu_op_t         alu_op_s;
   logic [XLEN-1:0] result_d;
   logic            take_branch_s;
   logic            unused_funct7_s;

   // Only funct7[5] distinguishes SUB/SRA; the rest of the field is don't-care here.
   assign unused_funct7_s = ^{funct7[6], funct7[4:0]};

   // ALU operation decode; FSM flags override the opcode
   always_comb begin
      alu_op_s = ALU_ADD;
      if (is_branch) begin
         alu_op_s = ALU_SUB;
      end else if (is_jalr) begin
         alu_op_s = ALU_ADD;
      end else begin
         case (opcode)
            OP_R, OP_IMM: begin
               case (funct3)
                  3'b000: begin
                     if ((opcode == OP_R) && funct7[5]) alu_op_s = ALU_SUB;
                     else                               alu_op_s = ALU_ADD;
                  end
                  3'b001: alu_op_s = ALU_SLL;
                  3'b010: alu_op_s = ALU_SLT;
                  3'b011: alu_op_s = ALU_SLTU;
                  3'b100: alu_op_s = ALU_XOR;
                  3'b101: begin
                     if (funct7[5]) alu_op_s = ALU_SRA;
                     else           alu_op_s = ALU_SRL;
                  end
                  3'b110: alu_op_s = ALU_OR;
                  3'b111: alu_op_s = ALU_AND;
                  default: alu_op_s = ALU_ADD;
               endcase
            end
            OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: alu_op_s = ALU_ADD;
            default: alu_op_s = ALU_ADD;
         endcase
      end
   end

   rv32_alu_core u_alu_core (
      .a           (a),
      .b           (b),
      .alu_op      (alu_op_s),
      .result      (result_d),
      .zero        (zero),
      .less_than   (less_than),
      .less_than_u (less_than_u)
   );

   // Branch condition; BEQ/BNE rely on zero from the forced SUB
   always_comb begin
      take_branch_s = 1'b0;
      if (is_branch) begin
         case (funct3)
            BR_BEQ:  take_branch_s = zero;
            BR_BNE:  take_branch_s = ~zero;
            BR_BLT:  take_branch_s = less_than;
            BR_BGE:  take_branch_s = ~less_than;
            BR_BLTU: take_branch_s = less_than_u;
            BR_BGEU: take_branch_s = ~less_than_u;
            default: take_branch_s = 1'b0;
         endcase
      end else begin
         take_branch_s = 1'b0;
      end
   end

   // Result register for address generation / write-back next cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) result_q <= 32'd0;
      else        result_q <= result_d;
   end

   assign alu_op      = alu_op_s;
   assign result      = result_d;
   assign take_branch = take_branch_s;

endmodule

// File: tb/tb_rv32_exec_unit.sv
// Directed and randomized checks of rv32_exec_unit against a behavioural model.
module tb_rv32_exec_unit;

   logic        clk;
   logic        rst_n;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        is_branch;
   logic        is_jalr;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  alu_op;
   logic [31:0] result;
   logic [31:0] result_q;
   logic        zero;
   logic        less_than;
   logic        less_than_u;
   logic        take_branch;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_res;

   rv32_exec_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .opcode      (opcode),
      .funct3      (funct3),
      .funct7      (funct7),
      .is_branch   (is_branch),
      .is_jalr     (is_jalr),
      .a           (a),
      .b           (b),
      .alu_op      (alu_op),
      .result      (result),
      .result_q    (result_q),
      .zero        (zero),
      .less_than   (less_than),
      .less_than_u (less_than_u),
      .take_branch (take_branch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: operation chosen from the decode rules
   function automatic logic [3:0] m_op(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7, input logic br, input logic jr);
      logic [3:0] tbl [8];
      tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
      if (br) return 4'd1;
      if (jr) return 4'd0;
      if (op != 7'b0110011 && op != 7'b0010011) return 4'd0;
      if (f3 == 3'd5 && f7[5]) return 4'd7;
      if (f3 == 3'd0 && f7[5] && op == 7'b0110011) return 4'd1;
      return tbl[f3];
   endfunction

   function automatic logic m_slt(input logic [31:0] x, input logic [31:0] y);
      if (x[31] != y[31]) return x[31];
      return (x < y);
   endfunction

   function automatic logic [31:0] m_res(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      int sh;
      logic [31:0] ones;
      sh = int'(y % 32'd32);
      ones = 32'hFFFF_FFFF;
      case (op)
         4'd0: return x + y;
         4'd1: return x - y;
         4'd2: return x << sh;
         4'd3: return m_slt(x, y) ? 32'd1 : 32'd0;
         4'd4: return (x < y) ? 32'd1 : 32'd0;
         4'd5: return x ^ y;
         4'd6: return x >> sh;
         4'd7: return (x >> sh) | (x[31] ? ~(ones >> sh) : 32'd0);
         4'd8: return x | y;
         4'd9: return x & y;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic m_take(input logic [2:0] f3, input logic br, input logic [31:0] x, input logic [31:0] y);
      if (!br) return 1'b0;
      case (f3)
         3'd0: return x == y;
         3'd1: return x != y;
         3'd4: return m_slt(x, y);
         3'd5: return !m_slt(x, y);
         3'd6: return x < y;
         3'd7: return x >= y;
         default: return 1'b0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic br, input logic jr, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      opcode = op; funct3 = f3; funct7 = f7; is_branch = br; is_jalr = jr; a = x; b = y;
      #1;
   endtask

   task automatic check_model(input string tag);
      logic [3:0] eop;
      eop = m_op(opcode, funct3, funct7, is_branch, is_jalr);
      exp_res = m_res(eop, a, b);
      check({tag, ".alu_op"}, {28'd0, alu_op}, {28'd0, eop});
      check({tag, ".result"}, result, exp_res);
      check({tag, ".zero"}, {31'd0, zero}, {31'd0, exp_res == 32'd0});
      check({tag, ".lt"}, {31'd0, less_than}, {31'd0, m_slt(a, b)});
      check({tag, ".ltu"}, {31'd0, less_than_u}, {31'd0, a < b});
      check({tag, ".take"}, {31'd0, take_branch}, {31'd0, m_take(funct3, is_branch, a, b)});
   endtask

   initial begin
      logic [6:0] ops [10];
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
      rst_n = 1'b0;
      opcode = 7'b0110011; funct3 = 3'd0; funct7 = 7'd0; is_branch = 1'b0; is_jalr = 1'b0;
      a = 32'd5; b = 32'd7;
      #3;
      check("reset_q", result_q, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ADD and one-cycle register latency
      drive(7'b0110011, 3'd0, 7'd0, 1'b0, 1'b0, 32'd5, 32'd7);
      check("add.result", result, 32'd12);
      check("add.alu_op", {28'd0, alu_op}, 32'd0);
      @(posedge clk); #1;
      check("add.result_q", result_q, 32'd12);
      #2 rst_n = 1'b0;
      #1 check("midreset_q", result_q, 32'd0);
      check("midreset.result", result, 32'd12);
      @(negedge clk);
      rst_n = 1'b1;

      drive(7'b0110011, 3'd0, 7'b0100000, 1'b0, 1'b0, 32'd5, 32'd7);
      check("r_sub", result, 32'hFFFF_FFFE);
      drive(7'b0010011, 3'd0, 7'b0100000, 1'b0, 1'b0, 32'd5, 32'd7);
      check("i_add", result, 32'd12);

      drive(7'b0110011, 3'd5, 7'd0, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0024);
      check("srl", result, 32'h0800_0000);
      drive(7'b0110011, 3'd5, 7'b0100000, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0024);
      check("sra", result, 32'hF800_0000);
      drive(7'b0010011, 3'd1, 7'd0, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0024);
      check("sll", result, 32'd0);
      check("sll.zero", {31'd0, zero}, 32'd1);

      drive(7'b0110011, 3'd2, 7'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
      check("slt", result, 32'd1);
      check("slt.lt", {31'd0, less_than}, 32'd1);
      check("slt.ltu", {31'd0, less_than_u}, 32'd0);
      drive(7'b0110011, 3'd3, 7'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
      check("sltu", result, 32'd0);

      drive(7'b1100011, 3'd0, 7'd0, 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
      check("edge.zero", {31'd0, zero}, 32'd1);
      check("edge.lt", {31'd0, less_than}, 32'd0);
      drive(7'b0110011, 3'd0, 7'd0, 1'b0, 1'b0, 32'h8000_0000, 32'd1);
      check("edge2.lt", {31'd0, less_than}, 32'd1);
      check("edge2.ltu", {31'd0, less_than_u}, 32'd0);

      drive(7'b1100011, 3'd0, 7'd0, 1'b1, 1'b0, 32'd9, 32'd9);
      check("beq", {31'd0, take_branch}, 32'd1);
      drive(7'b1100011, 3'd1, 7'd0, 1'b1, 1'b0, 32'd9, 32'd9);
      check("bne", {31'd0, take_branch}, 32'd0);
      drive(7'b1100011, 3'd5, 7'd0, 1'b1, 1'b0, 32'd9, 32'd9);
      check("bge", {31'd0, take_branch}, 32'd1);
      drive(7'b1100011, 3'd4, 7'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1);
      check("blt", {31'd0, take_branch}, 32'd1);
      drive(7'b1100011, 3'd6, 7'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1);
      check("bltu", {31'd0, take_branch}, 32'd0);
      drive(7'b1100011, 3'd7, 7'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1);
      check("bgeu", {31'd0, take_branch}, 32'd1);
      drive(7'b1100011, 3'd2, 7'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1);
      check("br010", {31'd0, take_branch}, 32'd0);
      for (int f = 0; f < 8; f++) begin
         drive(7'b1100011, 3'(f), 7'd0, 1'b0, 1'b0, 32'd9, 32'd9);
         check("nobranch", {31'd0, take_branch}, 32'd0);
      end

      drive(7'b1100111, 3'd7, 7'd0, 1'b0, 1'b1, 32'd100, 32'd4);
      check("jalr.op", {28'd0, alu_op}, 32'd0);
      check("jalr.result", result, 32'd104);
      for (int i = 2; i < 10; i++) begin
         drive(ops[i], 3'd7, 7'b0100000, 1'b0, 1'b0, 32'd3, 32'd4);
         check("other.op", {28'd0, alu_op}, 32'd0);
      end

      // Randomized sweep against the model, including register latency
      for (int i = 0; i < 400; i++) begin
         logic [31:0] x, y;
         logic [6:0]  f7;
         x = $urandom();
         y = $urandom();
         if ($urandom_range(0, 7) == 0) y = x;
         if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
         case ($urandom_range(0, 2))
            0: f7 = 7'd0;
            1: f7 = 7'b0100000;
            default: f7 = 7'($urandom());
         endcase
         drive(ops[$urandom_range(0, 9)], 3'($urandom_range(0, 7)), f7,
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), x, y);
         check_model("rand");
         @(posedge clk); #1;
         check("rand.result_q", result_q, exp_res);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rv32_exec_unit.md
Name: rv32_exec_unit

Overview:
- Execute-stage block of the multicycle RV32I core.
- Combines three functions:
  - ALU-operation decode from opcode/funct3/funct7.
  - The 32-bit integer ALU with comparison flags.
  - Branch-condition evaluation.
- Also holds the ALU result register that feeds memory addressing and register write-back on the next cycle.

Parameters:
- none (datapath fixed at 32 bits, RV32I)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- opcode  input  7  instruction opcode field
- funct3  input  3  instruction funct3 field
- funct7  input  7  instruction funct7 field
- is_branch  input  1  FSM flag: current instruction is a conditional branch
- is_jalr  input  1  FSM flag: current instruction is JALR
- a  input  32  ALU operand A (already muxed: rs1 / pc / 0)
- b  input  32  ALU operand B (already muxed: rs2 / imm / 4)
- alu_op  output  4  decoded operation (debug visibility)
- result  output  32  combinational ALU result
- result_q  output  32  registered ALU result
- zero  output  1  result == 0
- less_than  output  1  signed a < b
- less_than_u  output  1  unsigned a < b
- take_branch  output  1  branch condition satisfied

Behaviour:
- Everything combinational except result_q.
- result_q:
  - Async clear to 0 on rst_n low.
  - Otherwise loads result on every rising clk edge, with no enable; one-cycle latency.
  - Reset mid-operation clears it immediately.
- alu_op encoding:
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR
  - 0110 SRL, 0111 SRA, 1000 OR, 1001 AND
  - other codes: result = 0
- Decode priority:
  - is_branch=1 -> SUB.
  - else is_jalr=1 -> ADD.
  - else by opcode:
    - 0110011 (R-type): funct3 selects the operation:
      - 000: SUB if funct7[5]=1, else ADD
      - 001: SLL
      - 010: SLT
      - 011: SLTU
      - 100: XOR
      - 101: SRA if funct7[5]=1, else SRL
      - 110: OR
      - 111: AND
    - 0010011 (I-type): same mapping, except funct3 000 is always ADD (funct7 ignored, ADDI has no SUB); funct3 101 uses funct7[5] for SRAI/SRLI.
    - 0000011 load, 0100011 store, 1101111 JAL, 1100111 JALR, 0110111 LUI (FSM supplies a=0), 0010111 AUIPC: ADD.
    - any other opcode: ADD.
- Arithmetic:
  - ADD/SUB are modulo 2^32; no overflow flag.
  - Shift amount is b[4:0]; upper bits of b ignored.
  - SRA sign-extends from a[31].
  - SLT/SLTU produce 32'd1 or 32'd0.
- Flags:
  - zero derives from result.
  - less_than and less_than_u compare a and b directly and are valid regardless of alu_op.
- take_branch:
  - 0 when is_branch=0.
  - Otherwise by funct3:
    - 000 BEQ: zero
    - 001 BNE: !zero
    - 100 BLT: less_than
    - 101 BGE: !less_than
    - 110 BLTU: less_than_u
    - 111 BGEU: !less_than_u
    - 010/011: 0
- Edge cases:
  - a=b=32'h8000_0000 under SUB gives zero=1, less_than=0.
  - a=32'h8000_0000 vs b=1: less_than=1, less_than_u=0.
- No X propagation: all case statements have defaults.

Decomposition:
- Shared package rv32_pkg:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - alu_op_t enum (4-bit codes above)
  - branch funct3 constants
- One natural sub-module: rv32_alu_core, the pure combinational datapath (a, b, alu_op -> result, zero, less_than, less_than_u).
- Decode, branch logic and result_q live in the top.

Test Plan:
- Reset and register: assert rst_n=0 with result nonzero -> result_q=0 immediately. Release; opcode=0110011, funct3=000, funct7=0, a=5, b=7 -> result=12, alu_op=0000, result_q=12 after one clk edge.
- R vs I decode: funct3=000, funct7=0100000:
  - opcode 0110011 -> SUB, a=5, b=7 gives 32'hFFFF_FFFE.
  - opcode 0010011 -> ADD, result 12.
- Shifts: a=32'h8000_0000, b=32'h0000_0024 (amount 4):
  - SRL -> 32'h0800_0000
  - SRA -> 32'hF800_0000
  - SLL -> 0, zero=1
- Compares: a=32'hFFFF_FFFF, b=1:
  - SLT -> 1, SLTU -> 0
  - less_than=1, less_than_u=0
- Branches: is_branch=1, opcode=1100011, a=b=9:
  - funct3 000 -> take_branch=1; 001 -> 0; 101 -> 1.
  - a=-1, b=1: 100 -> 1, 110 -> 0, 111 -> 1; funct3=010 -> 0.
  - With is_branch=0 -> take_branch=0 for all funct3.
- Jump/other decode: is_jalr=1 with funct3=111 -> ADD. Opcodes LUI/AUIPC/load/store and unknown opcode 1111111 -> alu_op=0000.
